// File: rtl/square_wave_meter_pkg.sv
// Shared definitions for the square-wave meter and the display driver that reads its results.
package square_wave_meter_pkg;

    typedef enum logic [1:0] {
        WAIT_RISE = 2'd0,
        MEAS_HIGH = 2'd1,
        MEAS_LOW  = 2'd2
    } meter_state_t;

    localparam int          DEFAULT_CNT_W   = 32;
    localparam int unsigned DEFAULT_TIMEOUT = 200_000_000;

endpackage

// File: rtl/square_wave_meter_sync_edge_detect.sv
// Three-flop synchronizer for an asynchronous input, producing a clean level
// plus single-cycle rise/fall pulses. Also used for switches and buttons.
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;
    assign fall  = ~s2 & s3;

endmodule

// File: rtl/square_wave_meter.sv
// Measures high time, low time and period of a slow asynchronous square wave in
// clock cycles, and flags an input that has stopped toggling.
module square_wave_meter
    import square_wave_meter_pkg::*;
#(
    parameter int          CNT_W   = DEFAULT_CNT_W,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             CLK100MHZ,
    input  logic             RST,
    input  logic             SIG_IN,
    output logic [CNT_W-1:0] HIGH_CNT,
    output logic [CNT_W-1:0] LOW_CNT,
    output logic [CNT_W:0]   PERIOD_CNT,
    output logic             MEAS_VALID,
    output logic             STUCK,
    output logic             LEVEL
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    logic             rise;
    logic             fall;
    logic             any_edge;
    logic             timed_out;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] hi_tmp;
    meter_state_t     state;

    sync_edge_detect u_sync (
        .clk   (CLK100MHZ),
        .rst   (RST),
        .din   (SIG_IN),
        .level (LEVEL),
        .rise  (rise),
        .fall  (fall)
    );

    assign any_edge  = rise | fall;
    // An edge on the saturation cycle takes precedence over the timeout.
    assign timed_out = (count == TIMEOUT_CNT) & ~any_edge;

    // Restarting at 1 on an edge makes the latched count equal the edge spacing.
    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            count <= '0;
        end else if (any_edge) begin
            count <= CNT_W'(1);
        end else if (count != TIMEOUT_CNT) begin
            count <= count + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            state      <= WAIT_RISE;
            hi_tmp     <= '0;
            HIGH_CNT   <= '0;
            LOW_CNT    <= '0;
            PERIOD_CNT <= '0;
            MEAS_VALID <= 1'b0;
            STUCK      <= 1'b0;
        end else begin
            MEAS_VALID <= 1'b0;
            case (state)
                WAIT_RISE: begin
                    if (rise) begin
                        STUCK <= 1'b0;
                        state <= MEAS_HIGH;
                    end else if (timed_out) begin
                        STUCK <= 1'b1;
                    end
                end
                MEAS_HIGH: begin
                    if (fall) begin
                        hi_tmp <= count;
                        state  <= MEAS_LOW;
                    end else if (timed_out) begin
                        STUCK <= 1'b1;
                        state <= WAIT_RISE;
                    end
                end
                MEAS_LOW: begin
                    if (rise) begin
                        HIGH_CNT   <= hi_tmp;
                        LOW_CNT    <= count;
                        PERIOD_CNT <= {1'b0, hi_tmp} + {1'b0, count};
                        MEAS_VALID <= 1'b1;
                        state      <= MEAS_HIGH;
                    end else if (timed_out) begin
                        STUCK <= 1'b1;
                        state <= WAIT_RISE;
                    end
                end
                default: begin
                    state <= WAIT_RISE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_square_wave_meter.sv
// Directed bench for square_wave_meter: a short-timeout instance for the stuck
// logic and a long-timeout instance for the stretched clock-divider waveform.
module tb_square_wave_meter;

    localparam int          CNT_W    = 32;
    localparam int unsigned SHORT_TO = 1000;
    localparam int unsigned LONG_TO  = 5000;

    typedef struct {
        int     hi_len;
        int     lo_len;
        int     periods;
        bit     short_ok;
        longint exp_high;
        longint exp_low;
        longint exp_period;
    } vec_t;

    typedef struct {
        logic [CNT_W-1:0] high;
        logic [CNT_W-1:0] low;
        logic [CNT_W:0]   period;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    logic sig_in;

    logic [CNT_W-1:0] high_s, low_s, high_l, low_l;
    logic [CNT_W:0]   period_s, period_l;
    logic             valid_s, stuck_s, level_s;
    logic             valid_l, stuck_l, level_l;

    res_t q_short[$];
    res_t q_long[$];
    int   double_s = 0;
    int   double_l = 0;
    logic prev_valid_s = 1'b0;
    logic prev_valid_l = 1'b0;

    int   checks = 0;
    int   failures = 0;
    vec_t vectors[7];

    always #5 clk = ~clk;

    square_wave_meter #(.CNT_W(CNT_W), .TIMEOUT(SHORT_TO)) dut_short (
        .CLK100MHZ  (clk),
        .RST        (rst),
        .SIG_IN     (sig_in),
        .HIGH_CNT   (high_s),
        .LOW_CNT    (low_s),
        .PERIOD_CNT (period_s),
        .MEAS_VALID (valid_s),
        .STUCK      (stuck_s),
        .LEVEL      (level_s)
    );

    square_wave_meter #(.CNT_W(CNT_W), .TIMEOUT(LONG_TO)) dut_long (
        .CLK100MHZ  (clk),
        .RST        (rst),
        .SIG_IN     (sig_in),
        .HIGH_CNT   (high_l),
        .LOW_CNT    (low_l),
        .PERIOD_CNT (period_l),
        .MEAS_VALID (valid_l),
        .STUCK      (stuck_l),
        .LEVEL      (level_l)
    );

    // Collect every completed measurement and catch strobes longer than one cycle.
    always @(negedge clk) begin
        if (valid_s) q_short.push_back('{high_s, low_s, period_s});
        if (valid_l) q_long.push_back('{high_l, low_l, period_l});
        if (valid_s && prev_valid_s) double_s++;
        if (valid_l && prev_valid_l) double_l++;
        prev_valid_s = valid_s;
        prev_valid_l = valid_l;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic level, input int cycles);
        sig_in = level;
        repeat (cycles) tick();
    endtask

    task automatic applyReset(input logic level);
        rst    = 1'b1;
        sig_in = level;
        repeat (2) tick();
        rst = 1'b0;
        q_short.delete();
        q_long.delete();
    endtask

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkQueue(input string tag, input bit use_long, input int n,
                              input longint h, input longint l, input longint p);
        int   sz;
        res_t r;
        sz = use_long ? q_long.size() : q_short.size();
        checkOutput({tag, "_count"}, sz, n);
        for (int i = 0; i < sz && i < n; i++) begin
            r = use_long ? q_long[i] : q_short[i];
            checkOutput({tag, "_high"}, r.high, h);
            checkOutput({tag, "_low"}, r.low, l);
            checkOutput({tag, "_period"}, r.period, p);
        end
    endtask

    initial begin
        rst    = 1'b1;
        sig_in = 1'b0;

        vectors[0] = '{200, 100, 3, 1'b1, 200, 100, 300};
        vectors[1] = '{2000, 1000, 1, 1'b0, 2000, 1000, 3000};
        vectors[2] = '{1, 1, 4, 1'b1, 1, 1, 2};
        vectors[3] = '{40, 60, 2, 1'b1, 40, 60, 100};
        vectors[4] = '{1000, 50, 1, 1'b1, 1000, 50, 1050};
        vectors[5] = '{7, 1000, 1, 1'b1, 7, 1000, 1007};
        vectors[6] = '{3, 2, 3, 1'b1, 3, 2, 5};

        // Reset values and the two-cycle synchronizer latency on LEVEL.
        applyReset(1'b0);
        checkOutput("reset_high", high_s, 0);
        checkOutput("reset_low", low_s, 0);
        checkOutput("reset_period", period_s, 0);
        checkOutput("reset_valid", valid_s, 0);
        checkOutput("reset_stuck", stuck_s, 0);
        checkOutput("reset_level", level_s, 0);
        sig_in = 1'b1;
        tick();
        checkOutput("level_after_1", level_s, 0);
        tick();
        checkOutput("level_after_2", level_s, 1);

        for (int v = 0; v < 7; v++) begin
            applyReset(1'b0);
            applyStimulus(1'b0, 5);
            for (int k = 0; k < vectors[v].periods; k++) begin
                applyStimulus(1'b1, vectors[v].hi_len);
                applyStimulus(1'b0, vectors[v].lo_len);
            end
            applyStimulus(1'b1, 8);
            $display("[TB] vector %0d: %0d high / %0d low x%0d", v,
                     vectors[v].hi_len, vectors[v].lo_len, vectors[v].periods);
            checkQueue("vec_long", 1'b1, vectors[v].periods,
                       vectors[v].exp_high, vectors[v].exp_low, vectors[v].exp_period);
            if (vectors[v].short_ok) begin
                checkQueue("vec_short", 1'b0, vectors[v].periods,
                           vectors[v].exp_high, vectors[v].exp_low, vectors[v].exp_period);
                checkOutput("vec_short_stuck", stuck_s, 0);
            end
        end

        // Input held high past the timeout in the middle of a measurement.
        applyReset(1'b0);
        applyStimulus(1'b0, 5);
        applyStimulus(1'b1, 200);
        applyStimulus(1'b0, 100);
        sig_in = 1'b1;
        repeat (1002) tick();
        checkOutput("stuck_before_limit", stuck_s, 0);
        tick();
        checkOutput("stuck_at_limit", stuck_s, 1);
        repeat (1500 - 1003) tick();
        checkOutput("stuck_results", q_short.size(), 1);
        checkOutput("stuck_hold_high", high_s, 200);
        checkOutput("stuck_hold_low", low_s, 100);
        checkOutput("stuck_hold_period", period_s, 300);
        applyStimulus(1'b0, 10);
        checkOutput("stuck_after_fall", stuck_s, 1);
        sig_in = 1'b1;
        repeat (2) tick();
        checkOutput("stuck_before_rise_seen", stuck_s, 1);
        tick();
        checkOutput("stuck_clear_on_rise", stuck_s, 0);
        repeat (7) tick();
        applyStimulus(1'b0, 10);
        applyStimulus(1'b1, 8);
        checkOutput("recover_results", q_short.size(), 2);
        checkOutput("recover_high", high_s, 10);
        checkOutput("recover_low", low_s, 10);
        checkOutput("recover_period", period_s, 20);

        // Reset pulse while measuring the low phase.
        applyReset(1'b0);
        applyStimulus(1'b0, 5);
        applyStimulus(1'b1, 200);
        applyStimulus(1'b0, 100);
        applyStimulus(1'b1, 50);
        applyStimulus(1'b0, 20);
        checkOutput("pre_reset_high", high_s, 200);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midreset_high", high_s, 0);
        checkOutput("midreset_low", low_s, 0);
        checkOutput("midreset_period", period_s, 0);
        checkOutput("midreset_valid", valid_s, 0);
        checkOutput("midreset_stuck", stuck_s, 0);
        checkOutput("midreset_level", level_s, 0);
        q_short.delete();
        q_long.delete();
        applyStimulus(1'b0, 30);
        applyStimulus(1'b1, 40);
        applyStimulus(1'b0, 60);
        applyStimulus(1'b1, 8);
        checkQueue("after_reset", 1'b0, 1, 40, 60, 100);

        // Input already high when reset releases; later periods are 30/70.
        applyReset(1'b1);
        applyStimulus(1'b1, 50);
        applyStimulus(1'b0, 70);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, 30);
            applyStimulus(1'b0, 70);
        end
        applyStimulus(1'b1, 8);
        checkOutput("start_high_enough", q_short.size() >= 2, 1);
        if (q_short.size() >= 2) begin
            checkOutput("start_high_last_high", q_short[q_short.size()-1].high, 30);
            checkOutput("start_high_last_low", q_short[q_short.size()-1].low, 70);
            checkOutput("start_high_prev_high", q_short[q_short.size()-2].high, 30);
            checkOutput("start_high_prev_period", q_short[q_short.size()-2].period, 100);
        end

        checkOutput("strobe_width_short", double_s, 0);
        checkOutput("strobe_width_long", double_l, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
